sha_digest_axis_tx: RTL and testbench
=====================================

Name: sha_digest_axis_tx

Overview:
- Output side of the SHA-3 datapath. Captures the final Keccak state from keccak_xor and truncates it to the selected digest length.
- Streams the digest out as AXI-Stream beats (TDATA/TVALID/TREADY/TLAST/TKEEP/TID/TUSER), in the same beat format that Axi_Stream_Receiver consumes.
- Mirrors the input path (Axi_Stream_Transmitter → AXI_reg → keccak_xor) in the reverse direction: the 1600-bit state goes back to a narrow stream.

Parameters:
- DATA_WIDTH, 16, TDATA width in bits; legal values 8, 16, 32, 64.
- ID_WIDTH, 2, TID width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset; asynchronous, active-low.
- state_in  in  [4:0][4:0][63:0]  Keccak state; lane L = state_in[y][x], L = x+5y.
- state_valid  in  1  state_in is final and should be sent.
- state_ready  out  1  block can accept a state (high only in IDLE).
- mode  in  2  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
- id_in  in  ID_WIDTH  stream ID to tag the digest.
- TREADY  in  1  downstream ready.
- TVALID  out  1  beat valid.
- TDATA  out  DATA_WIDTH  digest beat.
- TKEEP  out  DATA_WIDTH/8  byte enables.
- TLAST  out  1  final beat of digest.
- TID  out  ID_WIDTH  latched id_in.
- TUSER  out  4  {2'b00, latched mode}.
- busy  out  1  transfer in progress.

Behaviour:
- Reset values:
  - TVALID=0, TLAST=0, TDATA=0, TKEEP=0, TID=0, TUSER=0, busy=0, state_ready=1.
  - Beat counter=0, digest register=0.
- FSM states: IDLE, SEND.
- IDLE:
  - state_ready=1.
  - On state_valid=1, capture lanes 0..7 (512 bits) into the digest register, and latch mode and id_in.
  - Compute NBYTES = 28/32/48/64 and NBEATS = ceil(NBYTES*8/DATA_WIDTH).
  - Go to SEND.
- SEND:
  - TVALID=1 from the cycle after capture (latency 1).
  - Beat k carries digest bytes [k*DATA_WIDTH/8 +: DATA_WIDTH/8].
  - Byte j of the digest = lane[j/8] bits [8*(j%8)+7 : 8*(j%8)] (little-endian within each lane; lane 0 first).
  - Counter advances only on TVALID && TREADY.
  - TLAST=1 exactly on beat NBEATS-1.
- Handshake rules:
  - While TVALID=1 && TREADY=0, TDATA, TKEEP, TLAST, TID and TUSER are held stable.
  - TVALID never drops before the handshake completes.
- TKEEP:
  - All ones, except the final beat when NBYTES is not a multiple of DATA_WIDTH/8.
  - SHA3-224 with DATA_WIDTH=64: 4 beats, last TKEEP=8'h0F, unused bytes driven 0.
- Final handshake: on the TLAST handshake, TVALID falls next cycle and the FSM returns to IDLE. state_ready rises the same cycle as the return to IDLE. No back-to-back overlap.
- Input during SEND: state_valid, mode and id_in changes are ignored (latched values are used).
- TREADY held high: one beat per cycle. SHA3-256 at DATA_WIDTH=16 takes 16 beats, 17 cycles from capture to IDLE.
- Reset mid-transfer: all outputs go to reset values immediately (asynchronous); the partial digest is discarded.
- busy = (state==SEND).

Optional Feature:
- Macro: SHA_DIGEST_BYTESWAP_EN.
- Defined: bytes within each TDATA beat are reversed, so the first digest byte sits in the MSB byte. TKEEP is reversed to match.
- Undefined: the first digest byte sits in TDATA[7:0] (AXI-Stream little-endian default).

Decomposition:
- Shared package sha_axis_pkg:
  - sha_mode_t enum (SHA3_224..SHA3_512).
  - LANE_W=64, DIGEST_LANES=8.
  - function digest_bytes(sha_mode_t).
  - keccak_state_t typedef [4:0][4:0][63:0].
  - The existing transmitter/receiver also reuse this package.
- One sub-module is natural: sha_digest_beat_mux. It is combinational: 512-bit register + beat index + NBYTES in, TDATA/TKEEP/TLAST out, and it contains the byteswap generate.

Test Plan:
1. Lane 0 = 64'h66D71EBFF8C6FFA7 (SHA3-256 of the empty string, first 8 bytes), mode=1, DATA_WIDTH=16, TREADY=1 → 16 beats, first TDATA=16'hFFA7 (16'hA7FF with SHA_DIGEST_BYTESWAP_EN), TLAST only on beat 15, TUSER=4'h1.
2. Lanes set to an incrementing byte pattern 00..3F, mode=3 → 32 beats, beat k = {2k+1, 2k}, TLAST on beat 31. Then mode=0 → 14 beats, last TDATA=16'h1B1A.
3. DATA_WIDTH=64, mode=0 → 4 beats, final TKEEP=8'h0F, TDATA[63:32]=0, TLAST=1.
4. TREADY toggled randomly (including 5 consecutive low cycles mid-stream) → TDATA/TLAST held stable while stalled, no beat lost or duplicated, beat order intact.
5. state_valid pulsed and mode/id_in changed during SEND → ignored, state_ready=0. A new state is accepted the first cycle after the return to IDLE.
6. ARESETn asserted at beat 7 of 16 → TVALID=0 immediately. After release, state_ready=1, and a new capture starts from beat 0.

Source files
------------

// File: rtl/sha_axis_pkg.sv
// Shared SHA-3 AXI-Stream package: digest modes, Keccak state type and digest sizing.
// Used by the digest transmitter and by the input-side transmitter/receiver.
package sha_axis_pkg;

    localparam int LANE_W       = 64;
    localparam int DIGEST_LANES = 8;
    localparam int DIGEST_W     = LANE_W * DIGEST_LANES;
    localparam int NBYTES_W     = 7;
    localparam int BEAT_W       = 7;

    typedef logic [4:0][4:0][LANE_W-1:0] keccak_state_t;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha_mode_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } sha_tx_state_t;

    function automatic logic [NBYTES_W-1:0] digest_bytes(input sha_mode_t m);
        case (m)
            SHA3_224: digest_bytes = 7'd28;
            SHA3_256: digest_bytes = 7'd32;
            SHA3_384: digest_bytes = 7'd48;
            default:  digest_bytes = 7'd64;
        endcase
    endfunction

endpackage

// File: rtl/sha_digest_beat_mux.sv
// Selects one AXI-Stream beat out of the 512-bit digest register and derives TKEEP/TLAST.
// Define SHA_DIGEST_BYTESWAP_EN to place the first digest byte of each beat in the MSB byte.
module sha_digest_beat_mux
    import sha_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DIGEST_W-1:0]     digest,
    input  logic [BEAT_W-1:0]       beat,
    input  logic [NBYTES_W-1:0]     nbytes,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic [DATA_WIDTH/8-1:0] tkeep,
    output logic                    tlast
);

    localparam int BPB     = DATA_WIDTH / 8;
    localparam int BPB_LOG = $clog2(BPB);
    localparam int IDX_W   = 10;

    logic [7:0]            dbyte [DIGEST_LANES*8];
    logic [IDX_W-1:0]      base;
    logic [DATA_WIDTH-1:0] lin_data;
    logic [BPB-1:0]        lin_keep;
    logic [7:0]            nb_sum;
    logic [7:0]            nbeats;

    generate
        for (genvar j = 0; j < DIGEST_LANES*8; j++) begin : g_bytes
            assign dbyte[j] = digest[8*j +: 8];
        end
    endgenerate

    assign base = IDX_W'(beat) << BPB_LOG;

    // Bytes past the end of a short digest are driven zero with their keep bit cleared.
    always_comb begin
        lin_data = '0;
        lin_keep = '0;
        for (int i = 0; i < BPB; i++) begin
            if (IDX_W'(i) + base < IDX_W'(nbytes)) begin
                lin_data[8*i +: 8] = dbyte[6'(base + IDX_W'(i))];
                lin_keep[i]        = 1'b1;
            end
        end
    end

`ifdef SHA_DIGEST_BYTESWAP_EN
    generate
        for (genvar p = 0; p < BPB; p++) begin : g_swap
            assign tdata[8*p +: 8] = lin_data[8*(BPB-1-p) +: 8];
            assign tkeep[p]        = lin_keep[BPB-1-p];
        end
    endgenerate
`else
    assign tdata = lin_data;
    assign tkeep = lin_keep;
`endif

    assign nb_sum = {1'b0, nbytes} + 8'(BPB - 1);
    assign nbeats = nb_sum >> BPB_LOG;
    assign tlast  = (({1'b0, beat} + 8'd1) == nbeats);

endmodule

// File: rtl/sha_digest_axis_tx.sv
// Captures the final Keccak state, truncates it to the SHA-3 digest length and streams it out
// over AXI-Stream. Optional macro SHA_DIGEST_BYTESWAP_EN reverses bytes within each beat.
module sha_digest_axis_tx
    import sha_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  keccak_state_t           state_in,
    input  logic                    state_valid,
    output logic                    state_ready,
    input  logic [1:0]              mode,
    input  logic [ID_WIDTH-1:0]     id_in,
    input  logic                    TREADY,
    output logic                    TVALID,
    output logic [DATA_WIDTH-1:0]   TDATA,
    output logic [DATA_WIDTH/8-1:0] TKEEP,
    output logic                    TLAST,
    output logic [ID_WIDTH-1:0]     TID,
    output logic [3:0]              TUSER,
    output logic                    busy,
    output sha_tx_state_t           dbg_state
);

    localparam int KEEP_W = DATA_WIDTH / 8;

    sha_tx_state_t         state;
    logic [DIGEST_W-1:0]   digest_q;
    logic [DIGEST_W-1:0]   capture;
    logic [DIGEST_W-1:0]   mux_digest;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     mux_beat;
    logic [NBYTES_W-1:0]   nbytes_q;
    logic [NBYTES_W-1:0]   mux_nbytes;
    logic [DATA_WIDTH-1:0] mux_tdata;
    logic [KEEP_W-1:0]     mux_tkeep;
    logic                  mux_tlast;
    logic                  unused_lanes;

    // Only lanes 0..7 (x+5y) can contribute to a digest of at most 512 bits.
    generate
        for (genvar l = 0; l < DIGEST_LANES; l++) begin : g_capture
            assign capture[l*LANE_W +: LANE_W] = state_in[l/5][l%5];
        end
    endgenerate
    assign unused_lanes = ^{state_in[4:2], state_in[1][4:3]};

    // In IDLE the mux looks at the incoming state so beat 0 is ready at capture time;
    // in SEND it looks one beat ahead of the registered outputs.
    always_comb begin
        mux_digest = digest_q;
        mux_beat   = beat_q + BEAT_W'(1);
        mux_nbytes = nbytes_q;
        if (state == TX_IDLE) begin
            mux_digest = capture;
            mux_beat   = '0;
            mux_nbytes = digest_bytes(sha_mode_t'(mode));
        end
    end

    sha_digest_beat_mux #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_beat_mux (
        .digest (mux_digest),
        .beat   (mux_beat),
        .nbytes (mux_nbytes),
        .tdata  (mux_tdata),
        .tkeep  (mux_tkeep),
        .tlast  (mux_tlast)
    );

    // Handshake: a beat transfers on a rising ACLK with TVALID && TREADY; once TVALID is high it
    // stays high and TDATA/TKEEP/TLAST/TID/TUSER hold until that transfer. state_valid is taken
    // whenever state_ready (IDLE) is high at the clock edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= TX_IDLE;
            digest_q <= '0;
            nbytes_q <= '0;
            beat_q   <= '0;
            TVALID   <= 1'b0;
            TDATA    <= '0;
            TKEEP    <= '0;
            TLAST    <= 1'b0;
            TID      <= '0;
            TUSER    <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (state_valid) begin
                        digest_q <= capture;
                        nbytes_q <= mux_nbytes;
                        beat_q   <= '0;
                        TVALID   <= 1'b1;
                        TDATA    <= mux_tdata;
                        TKEEP    <= mux_tkeep;
                        TLAST    <= mux_tlast;
                        TID      <= id_in;
                        TUSER    <= {2'b00, mode};
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (TVALID && TREADY) begin
                        if (TLAST) begin
                            TVALID <= 1'b0;
                            TLAST  <= 1'b0;
                            TDATA  <= '0;
                            TKEEP  <= '0;
                            state  <= TX_IDLE;
                        end else begin
                            beat_q <= mux_beat;
                            TDATA  <= mux_tdata;
                            TKEEP  <= mux_tkeep;
                            TLAST  <= mux_tlast;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign state_ready = (state == TX_IDLE);
    assign busy        = (state == TX_SEND);
    assign dbg_state   = state;

endmodule

// File: tb/tb_sha_digest_axis_tx.sv
// Self-checking bench for sha_digest_axis_tx: a 16-bit and a 64-bit instance checked against
// a byte-list reference model of the digest stream.
module tb_sha_digest_axis_tx;
    import sha_axis_pkg::*;

`ifdef SHA_DIGEST_BYTESWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic ACLK;
    logic ARESETn;
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- DUT, DATA_WIDTH = 16 ----------------
    keccak_state_t st16;
    logic          sv16, sr16, trdy16, tv16, tl16, busy16;
    logic [1:0]    mode16, id16, tid16;
    logic [15:0]   td16;
    logic [1:0]    tk16;
    logic [3:0]    tu16;
    sha_tx_state_t dbg16;

    sha_digest_axis_tx #(.DATA_WIDTH(16), .ID_WIDTH(2)) dut16 (
        .ACLK(ACLK), .ARESETn(ARESETn), .state_in(st16), .state_valid(sv16),
        .state_ready(sr16), .mode(mode16), .id_in(id16), .TREADY(trdy16),
        .TVALID(tv16), .TDATA(td16), .TKEEP(tk16), .TLAST(tl16), .TID(tid16),
        .TUSER(tu16), .busy(busy16), .dbg_state(dbg16)
    );

    // ---------------- DUT, DATA_WIDTH = 64 ----------------
    keccak_state_t st64;
    logic          sv64, sr64, trdy64, tv64, tl64, busy64;
    logic [1:0]    mode64, id64, tid64;
    logic [63:0]   td64;
    logic [7:0]    tk64;
    logic [3:0]    tu64;
    sha_tx_state_t dbg64;

    sha_digest_axis_tx #(.DATA_WIDTH(64), .ID_WIDTH(2)) dut64 (
        .ACLK(ACLK), .ARESETn(ARESETn), .state_in(st64), .state_valid(sv64),
        .state_ready(sr64), .mode(mode64), .id_in(id64), .TREADY(trdy64),
        .TVALID(tv64), .TDATA(td64), .TKEEP(tk64), .TLAST(tl64), .TID(tid64),
        .TUSER(tu64), .busy(busy64), .dbg_state(dbg64)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;          // 0: TREADY high, 1: random, 2: held low
    int beats_seen = 0;
    logic [15:0] last_data16;
    logic [24:0] exp_q[$];       // {tid, tuser, tlast, tkeep, tdata}
    int nb_tab[4] = '{28, 32, 48, 64};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void state_bytes(input keccak_state_t st, output logic [7:0] b[64]);
        for (int j = 0; j < 64; j++) begin
            int lane;
            lane = j / 8;
            b[j] = st[lane/5][lane%5][8*(j%8) +: 8];
        end
    endfunction

    // Returns {last, keep[7:0], data[63:0]} for beat k of a digest of nbytes bytes.
    function automatic logic [72:0] model_beat(input logic [7:0] b[64], input int nbytes,
                                               input int bpb, input int k);
        logic [63:0] d;
        logic [7:0]  kp;
        int nbeats, pos;
        d = '0;
        kp = '0;
        nbeats = (nbytes + bpb - 1) / bpb;
        for (int i = 0; i < bpb; i++) begin
            pos = SWAP ? (bpb - 1 - i) : i;
            if (k*bpb + i < nbytes) begin
                d[8*pos +: 8] = b[k*bpb + i];
                kp[pos] = 1'b1;
            end
        end
        return {(k == nbeats - 1), kp, d};
    endfunction

    task automatic model_push16(input keccak_state_t st, input logic [1:0] m, input logic [1:0] id);
        logic [7:0]  b[64];
        logic [72:0] r;
        int nb;
        state_bytes(st, b);
        nb = nb_tab[m];
        for (int k = 0; k < (nb + 1) / 2; k++) begin
            r = model_beat(b, nb, 2, k);
            exp_q.push_back({id, 2'b00, m, r[72], r[65:64], r[15:0]});
        end
    endtask

    function automatic keccak_state_t rand_state();
        keccak_state_t st;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                st[y][x] = {$urandom, $urandom};
        return st;
    endfunction

    function automatic keccak_state_t pattern_state();
        keccak_state_t st;
        st = rand_state();
        for (int j = 0; j < 64; j++) begin
            int lane;
            lane = j / 8;
            st[lane/5][lane%5][8*(j%8) +: 8] = 8'(j);
        end
        return st;
    endfunction

    // ---------------- TREADY driver ----------------
    initial begin
        trdy16 = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (ready_mode)
                0:       trdy16 = 1'b1;
                1:       trdy16 = 1'($urandom_range(0, 1));
                default: trdy16 = 1'b0;
            endcase
        end
    end

    // ---------------- monitor (16-bit stream) ----------------
    logic        stall_prev = 1'b0;
    logic [24:0] held;
    always @(negedge ACLK) begin
        logic [24:0] obs;
        obs = {tid16, tu16, tl16, tk16, td16};
        if (!ARESETn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_tvalid", 128'(tv16), 128'(1));
                check("hold_beat", 128'(obs), 128'(held));
            end
            if (tv16 && trdy16) begin
                beats_seen++;
                if (tl16) last_data16 = td16;
                if (exp_q.size() == 0) check("extra_beat", 128'(exp_q.size()), 128'(1));
                else                   check("beat", 128'(obs), 128'(exp_q.pop_front()));
            end
            stall_prev = tv16 && !trdy16;
            held = obs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready16();
        int t;
        t = 0;
        @(negedge ACLK);
        while (!sr16 && t < 300) begin
            @(negedge ACLK);
            t++;
        end
        if (!sr16) check("ready_timeout", 128'(sr16), 128'(1));
    endtask

    // Presents one state, then scrambles the inputs to show they are ignored during SEND.
    task automatic send16(input keccak_state_t st, input logic [1:0] m, input logic [1:0] id);
        wait_ready16();
        beats_seen = 0;
        @(posedge ACLK);
        #1;
        st16 = st; mode16 = m; id16 = id; sv16 = 1'b1;
        model_push16(st, m, id);
        @(posedge ACLK);
        #1;
        sv16 = 1'b0;
        st16 = rand_state();
        mode16 = 2'($urandom_range(0, 3));
        id16 = 2'($urandom_range(0, 3));
        @(negedge ACLK);
        check("latency_tvalid", 128'(tv16), 128'(1));
        check("send_ready_low", 128'(sr16), 128'(0));
    endtask

    task automatic wait_done16();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge ACLK);
            #1;
            t++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge ACLK);
        @(negedge ACLK);
        check("idle_tvalid", 128'(tv16), 128'(0));
        check("idle_ready", 128'(sr16), 128'(1));
        check("idle_busy", 128'(busy16), 128'(0));
    endtask

    task automatic send_check64(input keccak_state_t st, input logic [1:0] m);
        logic [7:0]  b[64];
        logic [72:0] r;
        int nb, nbeats, t;
        state_bytes(st, b);
        nb = nb_tab[m];
        nbeats = (nb + 7) / 8;
        t = 0;
        while (!sr64 && t < 100) begin
            @(negedge ACLK);
            t++;
        end
        @(posedge ACLK);
        #1;
        st64 = st; mode64 = m; id64 = 2'($urandom_range(0, 3)); sv64 = 1'b1;
        @(posedge ACLK);
        #1;
        sv64 = 1'b0;
        mode64 = 2'($urandom_range(0, 3));
        for (int k = 0; k < nbeats; k++) begin
            @(negedge ACLK);
            r = model_beat(b, nb, 8, k);
            check("w64_tvalid", 128'(tv64), 128'(1));
            check("w64_beat", 128'({tl64, tk64, td64}), 128'(r));
        end
        @(negedge ACLK);
        check("w64_done", 128'({tv64, sr64}), 128'(2'b01));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        keccak_state_t st_a, st_b;
        logic [1:0] m_b, id_a, id_b;
        int cycles;

        ARESETn = 1'b0;
        st16 = '0; sv16 = 1'b0; mode16 = 2'd0; id16 = 2'd0;
        st64 = '0; sv64 = 1'b0; mode64 = 2'd0; id64 = 2'd0; trdy64 = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_outputs16", 128'({tv16, tl16, td16, tk16, tid16, tu16, busy16}), 128'(0));
        check("rst_ready16", 128'(sr16), 128'(1));
        check("rst_dbg16", 128'(dbg16), 128'(TX_IDLE));
        check("rst_outputs64", 128'({tv64, tl64, td64, tk64, tid64, tu64, busy64}), 128'(0));
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // 1: SHA3-256 of the empty string, lane 0 only
        ready_mode = 0;
        st_a = '0;
        st_a[0][0] = 64'h66D71EBFF8C6FFA7;
        send16(st_a, 2'd1, 2'd2);
        check("t1_first_tdata", 128'(td16), SWAP ? 128'(16'hA7FF) : 128'(16'hFFA7));
        check("t1_tuser", 128'(tu16), 128'(4'h1));
        check("t1_tid", 128'(tid16), 128'(2'd2));
        check("t1_first_not_last", 128'(tl16), 128'(0));
        cycles = 1;
        while (!sr16 && cycles < 100) begin
            @(negedge ACLK);
            cycles++;
        end
        check("t1_cycles_to_idle", 128'(cycles), 128'(17));
        check("t1_beats", 128'(beats_seen), 128'(16));
        wait_done16();

        // 2: incrementing byte pattern, SHA3-512 then SHA3-224
        send16(pattern_state(), 2'd3, 2'd1);
        wait_done16();
        check("t2_beats_512", 128'(beats_seen), 128'(32));
        send16(pattern_state(), 2'd0, 2'd0);
        wait_done16();
        check("t2_beats_224", 128'(beats_seen), 128'(14));
        check("t2_last_224", 128'(last_data16), SWAP ? 128'(16'h1A1B) : 128'(16'h1B1A));

        // 3: 64-bit instance, SHA3-224 pattern then random states
        send_check64(pattern_state(), 2'd0);
        check("t3_last_keep", 128'(tk64), 128'(0));
        send_check64(rand_state(), 2'd2);
        send_check64(rand_state(), 2'($urandom_range(0, 3)));

        // 4: random TREADY with one 5-cycle stall mid-stream
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            send16(rand_state(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (i == 2) begin
                repeat (4) @(posedge ACLK);
                ready_mode = 2;
                repeat (5) @(posedge ACLK);
                ready_mode = 1;
            end
            wait_done16();
        end

        // 5: state_valid held during SEND is ignored until the return to IDLE
        ready_mode = 0;
        st_a = rand_state();
        id_a = 2'd3;
        send16(st_a, 2'd3, id_a);
        repeat (3) @(posedge ACLK);
        #1;
        st_b = rand_state();
        m_b = 2'($urandom_range(0, 3));
        id_b = 2'd1;
        st16 = st_b; mode16 = m_b; id16 = id_b; sv16 = 1'b1;
        model_push16(st_b, m_b, id_b);
        @(negedge ACLK);
        check("t5_ready_low", 128'(sr16), 128'(0));
        check("t5_tid_latched", 128'(tid16), 128'(id_a));
        check("t5_tuser_latched", 128'(tu16), 128'(4'h3));
        cycles = 0;
        while (!sr16 && cycles < 100) begin
            @(negedge ACLK);
            cycles++;
        end
        check("t5_gap", 128'({sr16, tv16}), 128'(2'b10));
        @(posedge ACLK);
        #1;
        sv16 = 1'b0;
        @(negedge ACLK);
        check("t5_reaccept", 128'({tv16, sr16}), 128'(2'b10));
        wait_done16();

        // 6: asynchronous reset at beat 7 of 16
        send16(rand_state(), 2'd1, 2'd2);
        repeat (7) @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        #1;
        check("t6_rst_tvalid", 128'(tv16), 128'(0));
        check("t6_rst_outputs", 128'({tl16, td16, tk16, tid16, tu16, busy16}), 128'(0));
        check("t6_rst_ready", 128'(sr16), 128'(1));
        exp_q.delete();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("t6_ready_after", 128'(sr16), 128'(1));
        send16(rand_state(), 2'd1, 2'd0);
        wait_done16();
        check("t6_beats_after", 128'(beats_seen), 128'(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
